fm_cmn_bram_arb: RTL and testbench
==================================

// Module: fm_cmn_bram_arb
// PURPOSE
//  Two-requester round-robin arbiter sharing port A of a single-clock
//  dual-port block RAM (write-first port A, 1-cycle registered read).
//  Each channel issues single-beat read/write commands on a req/ack handshake.
//  Read data returns on the owning channel with a strobe, tagged by channel.
//  Sits between two engines (e.g. texture/z caches) and one shared buffer RAM.
// PARAMETERS
//  P_WIDTH   32  data width, matches RAM word width
//  P_RANGE   9   address width; RAM depth = 1<<P_RANGE
//  P_REG_IN  0   1: register RAM command outputs (adds 1 cycle read latency)
// PORTS
//  clk_core      in   1        core clock; RAM port A uses the same clock
//  rst_x         in   1        asynchronous reset, active low
//  i_req0        in   1        ch0 command request
//  i_wr0         in   1        ch0 1=write 0=read, valid with i_req0
//  i_adrs0       in   P_RANGE  ch0 address
//  i_wdata0      in   P_WIDTH  ch0 write data
//  o_ack0        out  1        ch0 command accepted this cycle
//  o_rstr0       out  1        ch0 read data strobe
//  o_rdata0      out  P_WIDTH  ch0 read data, valid with o_rstr0
//  i_req1..o_rdata1            identical set for ch1
//  o_bram_we     out  1        RAM port A write enable
//  o_bram_adrs   out  P_RANGE  RAM port A address
//  o_bram_wdata  out  P_WIDTH  RAM port A write data
//  i_bram_rdata  in   P_WIDTH  RAM port A read data (1 cycle after address)
// BEHAVIOUR
//  - Handshake: command transfers in a cycle where req&ack=1. Requester holds
//    req/wr/adrs/wdata stable until acked. At most one ack per cycle.
//  - Arbitration (combinational on current req, registered r_last):
//    only req0 -> ack0; only req1 -> ack1; both -> ack the channel != r_last.
//    r_last <= granted channel on every ack; unchanged when no ack.
//  - No back-pressure from RAM: some request is always acked if any req=1.
//  - P_REG_IN=0: o_bram_* driven combinationally from granted channel;
//    o_bram_we = ack & wr. No grant -> we=0, adrs=0, wdata=0.
//  - P_REG_IN=1: o_bram_* are flops loaded from granted channel each cycle;
//    idle cycles load we=0, adrs=0, wdata=0.
//  - Read return: a read accepted in cycle N asserts o_rstrX for exactly one
//    cycle at N+1+P_REG_IN; o_rdataX = i_bram_rdata in that cycle.
//    Tracking pipe: valid+channel bit per stage, depth 1+P_REG_IN.
//  - Writes produce no strobe (write-first RAM echo on doa is ignored).
//  - o_rdataX may carry any value when o_rstrX=0; only X=owner strobes.
//  - Back-to-back reads fully pipelined: one return per cycle possible;
//    returns keep acceptance order; ch0/ch1 strobes never both high.
//  - Same-address write then read (either channel, consecutive cycles):
//    read returns the new data (RAM ordering, no bypass needed).
//  - Reset (rst_x=0, any time): r_last=1 (ch0 wins first tie), all pipe
//    valids=0, registered o_bram_we=0 / adrs=0 / wdata=0, o_rstr0/1=0;
//    in-flight reads are dropped, no strobe after reset release.
//  - o_ack0/1 are combinational and 0 while rst_x=0.
// TESTING
//  T1 reset: hold rst_x=0 with req0=req1=1 -> ack0=ack1=0, rstr0=rstr1=0,
//     o_bram_we=0; release -> first tie grants ch0.
//  T2 ch0 write 0x0A5=0xDEADBEEF, then ch1 read 0x0A5 -> rstr1 one cycle
//     after ack1 (P_REG_IN=0) with rdata1=0xDEADBEEF; rstr0 stays 0.
//  T3 both req held for 8 cycles (reads, adrs 0x10/0x20) -> acks alternate
//     0,1,0,1...; each read returns its own data on its channel in order.
//  T4 single requester ch1 streams 16 reads adrs 0..15 -> ack1 every cycle,
//     16 consecutive rstr1 with data matching preloaded RAM contents.
//  T5 P_REG_IN=1: read at cycle N -> rstr at N+2; write adrs 0x1FF then
//     read 0x1FF next cycle -> new data returned (wrap of top address).
//  T6 assert rst_x=0 the cycle after a read ack -> no strobe appears;
//     first tie after release grants ch0.

Source files
------------

// File: rtl/fm_cmn_bram_arb_if.sv
// Bus bundle for the two-channel block-RAM arbiter:
// two req/ack command channels, two read returns, one RAM port A.
interface fm_cmn_bram_arb_if #(
   parameter int P_WIDTH = 32,
   parameter int P_RANGE = 9
);
   logic               i_req0;
   logic               i_wr0;
   logic [P_RANGE-1:0] i_adrs0;
   logic [P_WIDTH-1:0] i_wdata0;
   logic               o_ack0;
   logic               o_rstr0;
   logic [P_WIDTH-1:0] o_rdata0;
   logic               i_req1;
   logic               i_wr1;
   logic [P_RANGE-1:0] i_adrs1;
   logic [P_WIDTH-1:0] i_wdata1;
   logic               o_ack1;
   logic               o_rstr1;
   logic [P_WIDTH-1:0] o_rdata1;
   logic               o_bram_we;
   logic [P_RANGE-1:0] o_bram_adrs;
   logic [P_WIDTH-1:0] o_bram_wdata;
   logic [P_WIDTH-1:0] i_bram_rdata;

   modport slave (
      input  i_req0, i_wr0, i_adrs0, i_wdata0,
      output o_ack0, o_rstr0, o_rdata0,
      input  i_req1, i_wr1, i_adrs1, i_wdata1,
      output o_ack1, o_rstr1, o_rdata1,
      output o_bram_we, o_bram_adrs, o_bram_wdata,
      input  i_bram_rdata
   );

   modport master (
      output i_req0, i_wr0, i_adrs0, i_wdata0,
      input  o_ack0, o_rstr0, o_rdata0,
      output i_req1, i_wr1, i_adrs1, i_wdata1,
      input  o_ack1, o_rstr1, o_rdata1,
      input  o_bram_we, o_bram_adrs, o_bram_wdata,
      output i_bram_rdata
   );
endinterface

// File: rtl/fm_cmn_bram_arb.sv
// Round-robin arbiter sharing RAM port A between two channels,
// with a valid/channel pipe that steers read returns back.
module fm_cmn_bram_arb #(
   parameter int P_WIDTH  = 32,
   parameter int P_RANGE  = 9,
   parameter int P_REG_IN = 0
) (
   input logic              clk_core,
   input logic              rst_x,
   fm_cmn_bram_arb_if.slave bus
);
   localparam int D = 1 + P_REG_IN;

   logic               last_q;
   logic               last_d;
   logic               gnt0;
   logic               gnt1;
   logic               rd_v;
   logic               we_d;
   logic [P_RANGE-1:0] adrs_d;
   logic [P_WIDTH-1:0] wdata_d;
   logic [D-1:0]       v_q;
   logic [D-1:0]       v_d;
   logic [D-1:0]       ch_q;
   logic [D-1:0]       ch_d;

   always_comb begin
      // tie goes to the channel that did not win last
      gnt0 = rst_x & bus.i_req0 & (~bus.i_req1 | last_q);
      gnt1 = rst_x & bus.i_req1 & (~bus.i_req0 | ~last_q);
      we_d    = 1'b0;
      adrs_d  = '0;
      wdata_d = '0;
      rd_v    = 1'b0;
      unique case (1'b1)
         gnt0: begin
            we_d    = bus.i_wr0;
            adrs_d  = bus.i_adrs0;
            wdata_d = bus.i_wdata0;
            rd_v    = ~bus.i_wr0;
         end
         gnt1: begin
            we_d    = bus.i_wr1;
            adrs_d  = bus.i_adrs1;
            wdata_d = bus.i_wdata1;
            rd_v    = ~bus.i_wr1;
         end
         default: ;
      endcase
      last_d = last_q;
      if (gnt0 | gnt1)
         last_d = gnt1;
      v_d[0]  = rd_v;
      ch_d[0] = gnt1;
      for (int i = 1; i < D; i++) begin
         v_d[i]  = v_q[i-1];
         ch_d[i] = ch_q[i-1];
      end
   end

   always_ff @(posedge clk_core or negedge rst_x) begin
      if (!rst_x) begin
         last_q <= 1'b1;
         v_q    <= '0;
         ch_q   <= '0;
      end else begin
         last_q <= last_d;
         v_q    <= v_d;
         ch_q   <= ch_d;
      end
   end

   assign bus.o_ack0   = gnt0;
   assign bus.o_ack1   = gnt1;
   assign bus.o_rstr0  = v_q[D-1] & ~ch_q[D-1];
   assign bus.o_rstr1  = v_q[D-1] & ch_q[D-1];
   assign bus.o_rdata0 = bus.i_bram_rdata;
   assign bus.o_rdata1 = bus.i_bram_rdata;

   generate
      if (P_REG_IN != 0) begin : g_reg
         logic               we_q;
         logic [P_RANGE-1:0] adrs_q;
         logic [P_WIDTH-1:0] wdata_q;

         always_ff @(posedge clk_core or negedge rst_x) begin
            if (!rst_x) begin
               we_q    <= 1'b0;
               adrs_q  <= '0;
               wdata_q <= '0;
            end else begin
               we_q    <= we_d;
               adrs_q  <= adrs_d;
               wdata_q <= wdata_d;
            end
         end

         assign bus.o_bram_we    = we_q;
         assign bus.o_bram_adrs  = adrs_q;
         assign bus.o_bram_wdata = wdata_q;
      end else begin : g_comb
         assign bus.o_bram_we    = we_d;
         assign bus.o_bram_adrs  = adrs_d;
         assign bus.o_bram_wdata = wdata_d;
      end
   endgenerate
endmodule

// File: tb/tb_fm_cmn_bram_arb.sv
// Bench for fm_cmn_bram_arb: two instances (P_REG_IN=0/1), each with
// its own write-first RAM model, and a read-return scoreboard.
module tb_fm_cmn_bram_arb;
   localparam int W = 32;
   localparam int R = 9;

   typedef struct {
      bit           wr;
      logic [R-1:0] adrs;
      logic [W-1:0] wdata;
   } cmd_t;

   typedef struct {
      bit           ch;
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_x;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         req0 [2];
   logic         wr0  [2];
   logic [R-1:0] adr0 [2];
   logic [W-1:0] wd0  [2];
   logic         req1 [2];
   logic         wr1  [2];
   logic [R-1:0] adr1 [2];
   logic [W-1:0] wd1  [2];
   logic         ack0 [2];
   logic         ack1 [2];
   logic         rstr0[2];
   logic         rstr1[2];
   logic [W-1:0] rd0  [2];
   logic [W-1:0] rd1  [2];
   logic         bwe  [2];
   logic [R-1:0] badr [2];
   logic [W-1:0] bwd  [2];
   logic [W-1:0] rdq  [2];

   fm_cmn_bram_arb_if #(.P_WIDTH(W), .P_RANGE(R)) bi0 ();
   fm_cmn_bram_arb_if #(.P_WIDTH(W), .P_RANGE(R)) bi1 ();

   fm_cmn_bram_arb #(.P_WIDTH(W), .P_RANGE(R), .P_REG_IN(0)) u_dut0 (
      .clk_core(clk),
      .rst_x   (rst_x),
      .bus     (bi0)
   );

   fm_cmn_bram_arb #(.P_WIDTH(W), .P_RANGE(R), .P_REG_IN(1)) u_dut1 (
      .clk_core(clk),
      .rst_x   (rst_x),
      .bus     (bi1)
   );

   assign bi0.i_req0   = req0[0];
   assign bi0.i_wr0    = wr0[0];
   assign bi0.i_adrs0  = adr0[0];
   assign bi0.i_wdata0 = wd0[0];
   assign bi0.i_req1   = req1[0];
   assign bi0.i_wr1    = wr1[0];
   assign bi0.i_adrs1  = adr1[0];
   assign bi0.i_wdata1 = wd1[0];
   assign bi1.i_req0   = req0[1];
   assign bi1.i_wr0    = wr0[1];
   assign bi1.i_adrs0  = adr0[1];
   assign bi1.i_wdata0 = wd0[1];
   assign bi1.i_req1   = req1[1];
   assign bi1.i_wr1    = wr1[1];
   assign bi1.i_adrs1  = adr1[1];
   assign bi1.i_wdata1 = wd1[1];
   assign ack0[0]  = bi0.o_ack0;
   assign ack1[0]  = bi0.o_ack1;
   assign rstr0[0] = bi0.o_rstr0;
   assign rstr1[0] = bi0.o_rstr1;
   assign rd0[0]   = bi0.o_rdata0;
   assign rd1[0]   = bi0.o_rdata1;
   assign ack0[1]  = bi1.o_ack0;
   assign ack1[1]  = bi1.o_ack1;
   assign rstr0[1] = bi1.o_rstr0;
   assign rstr1[1] = bi1.o_rstr1;
   assign rd0[1]   = bi1.o_rdata0;
   assign rd1[1]   = bi1.o_rdata1;
   assign bwe[0]   = bi0.o_bram_we;
   assign badr[0]  = bi0.o_bram_adrs;
   assign bwd[0]   = bi0.o_bram_wdata;
   assign bwe[1]   = bi1.o_bram_we;
   assign badr[1]  = bi1.o_bram_adrs;
   assign bwd[1]   = bi1.o_bram_wdata;
   assign bi0.i_bram_rdata = rdq[0];
   assign bi1.i_bram_rdata = rdq[1];

   function automatic logic [W-1:0] pre(input logic [R-1:0] a);
      return {16'hC0DE, 7'd0, a};
   endfunction

   // write-first RAM, 1-cycle registered read, preloaded with pre()
   logic [W-1:0] mem  [2][1<<R];
   bit           seen [2][1<<R];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (bwe[d]) begin
            mem[d][badr[d]]  <= bwd[d];
            seen[d][badr[d]] <= 1'b1;
            rdq[d]           <= bwd[d];
         end else begin
            rdq[d] <= seen[d][badr[d]] ? mem[d][badr[d]]
                                       : pre(badr[d]);
         end
      end
   end

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] model [2][1<<R];
   bit           last_g[2];
   cmd_t         cq0[$];
   cmd_t         cq1[$];
   exp_t         sbq0[$];
   exp_t         sbq1[$];
   bit           gseq[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_x === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            if (rstr0[d] | rstr1[d]) begin
               chk("strb_excl", 64'(rstr0[d] & rstr1[d]), 64'd0);
               if ((d == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0)) begin
                  chk("strb_unexp", 64'(rstr0[d] | rstr1[d]), 64'd0);
               end else begin
                  e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                  chk("rd_ch", 64'(rstr1[d]), 64'(e.ch));
                  chk("rd_data", 64'(rstr1[d] ? rd1[d] : rd0[d]),
                      64'(e.data));
                  chk("rd_cyc", 64'(cyc), 64'(e.cyc));
               end
            end
         end
      end
   end

   task automatic idle(input int d);
      req0[d] = 1'b0;
      wr0[d]  = 1'b0;
      adr0[d] = '0;
      wd0[d]  = '0;
      req1[d] = 1'b0;
      wr1[d]  = 1'b0;
      adr1[d] = '0;
      wd1[d]  = '0;
   endtask

   task automatic accept(input int d, input bit ch, input cmd_t c);
      exp_t e;
      last_g[d] = ch;
      gseq.push_back(ch);
      if (c.wr) begin
         model[d][c.adrs] = c.wdata;
      end else begin
         e.ch   = ch;
         e.data = model[d][c.adrs];
         e.cyc  = cyc + 1 + d;
         if (d == 0) sbq0.push_back(e);
         else        sbq1.push_back(e);
      end
   endtask

   // requesters hold each command until acked, then move to the next
   task automatic run(input int d, input int maxc, output int nc);
      bit a0;
      bit a1;
      nc = 0;
      while ((cq0.size() + cq1.size()) > 0 && nc < maxc) begin
         req0[d] = cq0.size() > 0;
         req1[d] = cq1.size() > 0;
         if (req0[d]) begin
            wr0[d]  = cq0[0].wr;
            adr0[d] = cq0[0].adrs;
            wd0[d]  = cq0[0].wdata;
         end
         if (req1[d]) begin
            wr1[d]  = cq1[0].wr;
            adr1[d] = cq1[0].adrs;
            wd1[d]  = cq1[0].wdata;
         end
         @(negedge clk);
         a0 = ack0[d];
         a1 = ack1[d];
         chk("one_ack", 64'(a0 & a1), 64'd0);
         chk("no_stall", 64'(a0 | a1), 64'(req0[d] | req1[d]));
         if (a0) accept(d, 1'b0, cq0.pop_front());
         if (a1) accept(d, 1'b1, cq1.pop_front());
         nc++;
         @(posedge clk);
         #1;
      end
      idle(d);
      chk("run_done", 64'(cq0.size() + cq1.size()), 64'd0);
      cq0.delete();
      cq1.delete();
   endtask

   initial begin
      int   nc;
      bit   first;
      cmd_t c;
      rst_x = 1'b1;
      for (int d = 0; d < 2; d++) begin
         idle(d);
         last_g[d] = 1'b1;
         for (int a = 0; a < (1 << R); a++)
            model[d][a] = pre(R'(a));
      end
      #1;
      rst_x = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req0[d] = 1'b1;
         req1[d] = 1'b1;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ack0", 64'(ack0[d]), 64'd0);
         chk("rst_ack1", 64'(ack1[d]), 64'd0);
         chk("rst_rstr0", 64'(rstr0[d]), 64'd0);
         chk("rst_rstr1", 64'(rstr1[d]), 64'd0);
         chk("rst_we", 64'(bwe[d]), 64'd0);
      end
      @(posedge clk);
      #1;
      rst_x = 1'b1;
      for (int d = 0; d < 2; d++) idle(d);

      for (int d = 0; d < 2; d++) begin
         // tie after reset: ch0 write first, ch1 reads it back
         gseq.delete();
         cq0.push_back('{1'b1, 9'h0A5, 32'hDEADBEEF});
         cq1.push_back('{1'b0, 9'h0A5, 32'h0});
         run(d, 10, nc);
         chk("tie_n", 64'(gseq.size()), 64'd2);
         if (gseq.size() > 0) chk("tie_first", 64'(gseq[0]), 64'd0);

         gseq.delete();
         first = ~last_g[d];
         for (int i = 0; i < 4; i++) begin
            cq0.push_back('{1'b0, R'(9'h010 + i), 32'h0});
            cq1.push_back('{1'b0, R'(9'h020 + i), 32'h0});
         end
         run(d, 20, nc);
         chk("alt_cycles", 64'(nc), 64'd8);
         for (int i = 0; i < gseq.size(); i++)
            chk("alt_gnt", 64'(gseq[i]), 64'(first ^ i[0]));

         for (int i = 0; i < 16; i++)
            cq1.push_back('{1'b0, R'(i), 32'h0});
         run(d, 40, nc);
         chk("stream_cycles", 64'(nc), 64'd16);

         cq0.push_back('{1'b0, 9'h030, 32'h0});
         cq0.push_back('{1'b1, 9'h1FF, 32'h12345678 + d});
         cq0.push_back('{1'b0, 9'h1FF, 32'h0});
         cq1.push_back('{1'b1, 9'h000, 32'hCAFE0000 + d});
         cq1.push_back('{1'b0, 9'h000, 32'h0});
         run(d, 20, nc);
         repeat (4) @(posedge clk);
         #1;
      end

      // reset lands the cycle after a read ack: the return is dropped
      for (int d = 0; d < 2; d++) begin
         req0[d] = 1'b1;
         adr0[d] = 9'h040;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("t6_ack", 64'(ack0[d]), 64'd1);
      @(posedge clk);
      #1;
      rst_x = 1'b0;
      for (int d = 0; d < 2; d++) begin
         idle(d);
         last_g[d] = 1'b1;
      end
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("t6_rstr0", 64'(rstr0[d]), 64'd0);
            chk("t6_rstr1", 64'(rstr1[d]), 64'd0);
            chk("t6_we", 64'(bwe[d]), 64'd0);
         end
      end
      @(posedge clk);
      #1;
      rst_x = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         gseq.delete();
         c = '{1'b0, 9'h0A5, 32'h0};
         cq0.push_back(c);
         c.adrs = 9'h011;
         cq1.push_back(c);
         run(d, 10, nc);
         if (gseq.size() > 0) chk("t6_tie", 64'(gseq[0]), 64'd0);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("sb0_empty", 64'(sbq0.size()), 64'd0);
      chk("sb1_empty", 64'(sbq1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
